// File: rtl/ram_burst_reader_pkg.sv
// Shared state encoding and default geometry for the RAM burst reader.
// No logic of its own; imported by the reader top and its buffer.
// The defaults match the RAM array so both sides agree on address and word width.
package ram_burst_reader_pkg;

    localparam int ADDRWIDTH_DEF = 8;
    localparam int DATAWIDTH_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ram_reader_skid.sv
// Two-entry valid/ready buffer; head entry drives the stream outputs directly.
// Latency: a push is visible at the head one cycle later when the buffer is empty.
// Backpressure: accepts a push while not full, or while full with a same-cycle pop.
module ram_reader_skid
    import ram_burst_reader_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATAWIDTH-1:0] push_data,
    output logic                 can_push,
    output logic [DATAWIDTH-1:0] head_data,
    output logic                 head_valid,
    input  logic                 pop_ready,
    output logic                 last_pop
);

    logic [DATAWIDTH-1:0] tail_data;
    logic                 tail_valid;
    logic                 pop;

    // Pop is a handshake on the head; full means the tail is occupied.
    always_comb begin
        pop      = head_valid & pop_ready;
        can_push = ~tail_valid | pop;
        last_pop = pop & ~tail_valid;
    end

    // Head/tail update: pops shift the tail forward, pushes fill the first free slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_data  <= '0;
            head_valid <= 1'b0;
            tail_data  <= '0;
            tail_valid <= 1'b0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (tail_valid) begin
                        head_data <= tail_data;
                        tail_data <= push_data;
                    end else begin
                        head_data <= push_data;
                    end
                end
                2'b01: begin
                    head_data  <= tail_data;
                    head_valid <= tail_valid;
                    tail_valid <= 1'b0;
                end
                2'b10: begin
                    if (!head_valid) begin
                        head_data  <= push_data;
                        head_valid <= 1'b1;
                    end else begin
                        tail_data  <= push_data;
                        tail_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ram_burst_reader.sv
// Walks the RAM read address from base_addr for len words and streams the data out.
// Latency: first word valid one cycle after the start-sampling edge; one word/cycle.
// Backpressure: m_ready low stalls the buffer, which freezes the address walk.
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int ADDRWIDTH = ADDRWIDTH_DEF,
    parameter int DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDRWIDTH-1:0] base_addr,
    input  logic [ADDRWIDTH:0]   len,
    output logic                 busy,
    output logic                 done,
    output logic [ADDRWIDTH-1:0] ram_a,
    input  logic [DATAWIDTH-1:0] ram_do,
    output logic [DATAWIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready
);

    state_t               state;
    state_t               state_nxt;
    logic [ADDRWIDTH:0]   rem;
    logic                 can_push;
    logic                 last_pop;
    logic                 push;
    logic                 accept;
    logic                 zero_req;
    logic                 done_nxt;
    logic                 last_push;

    ram_reader_skid #(
        .DATAWIDTH (DATAWIDTH)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (ram_do),
        .can_push   (can_push),
        .head_data  (m_data),
        .head_valid (m_valid),
        .pop_ready  (m_ready),
        .last_pop   (last_pop)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state: bursts of zero length never leave IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && len != '0) state_nxt = S_RUN;
            S_RUN:   if (last_push)          state_nxt = S_DRAIN;
            S_DRAIN: if (last_pop)           state_nxt = S_IDLE;
            default:                         state_nxt = S_IDLE;
        endcase
    end

    // Per-state control strobes.
    always_comb begin
        busy      = (state != S_IDLE);
        accept    = (state == S_IDLE) && start && (len != '0);
        zero_req  = (state == S_IDLE) && start && (len == '0);
        push      = (state == S_RUN) && can_push;
        last_push = push && (rem == (ADDRWIDTH+1)'(1));
        done_nxt  = zero_req || ((state == S_DRAIN) && last_pop);
    end

    // Address/remaining counters advance only on a push; done is a registered pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_a <= '0;
            rem   <= '0;
            done  <= 1'b0;
        end else begin
            done <= done_nxt;
            if (accept) begin
                ram_a <= base_addr;
                rem   <= len;
            end else if (push) begin
                ram_a <= ram_a + ADDRWIDTH'(1);
                rem   <= rem - (ADDRWIDTH+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a queue scoreboard and a negedge monitor.
module tb_ram_burst_reader;

    localparam int AW = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_do;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;

    logic [DW-1:0] mem [0:15];
    assign ram_do = mem[ram_a];

    ram_burst_reader #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ram_a     (ram_a),
        .ram_do    (ram_do),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] exp_q [$];
    int            ncyc = 0;
    int            beats = 0;
    int            done_cnt = 0;
    int            done_cyc = -1;
    int            first_valid_cyc = -1;
    int            last_beat_cyc = -1;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    bit            rdy_mode = 1'b0;
    logic          rdy_const = 1'b0;
    logic [3:0]    rdy_pat = 4'b1001;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: samples at negedge, pops the scoreboard on each accepted beat.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", m_valid, 1);
                    check("hold_data", m_data, prev_data);
                end
                if (m_valid && first_valid_cyc < 0) first_valid_cyc = ncyc;
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got data %0d expected no beat", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", m_data, e);
                    end
                    beats++;
                    last_beat_cyc = ncyc;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                if (done) begin
                    done_cnt++;
                    done_cyc = ncyc;
                end
            end
        end
    end

    // Ready driver: constant level or the 1,0,0,1 toggle pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = rdy_mode ? rdy_pat[ncyc % 4] : rdy_const;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input int b, input int l, output int t0);
        @(posedge clk);
        #1;
        base_addr = AW'(b);
        len       = (AW+1)'(l);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = ncyc;
    endtask

    task automatic wait_done(input string name, input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(name, done_cnt, target);
    endtask

    initial begin
        int t0;
        int d0;
        int b0;
        for (int i = 0; i < 16; i++) mem[i] = DW'(i) ^ 4'hA;

        // Reset state
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ram_a", ram_a, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_const = 1'b1;
        repeat (2) @(posedge clk);

        // 1: base=2 len=5, ready held high
        exp_q.push_back(4'h8); exp_q.push_back(4'h9); exp_q.push_back(4'hE);
        exp_q.push_back(4'hF); exp_q.push_back(4'hC);
        first_valid_cyc = -1;
        d0 = done_cnt; b0 = beats;
        issue(2, 5, t0);
        wait_done("t1_done", d0 + 1, 40);
        check("t1_first_valid", first_valid_cyc, t0 + 2);
        check("t1_last_beat", last_beat_cyc, t0 + 6);
        check("t1_beats", beats - b0, 5);
        check("t1_done_cyc", done_cyc, last_beat_cyc + 1);
        check("t1_q_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);

        // 2: wrap around the top of the address space
        exp_q.push_back(4'h4); exp_q.push_back(4'h5);
        exp_q.push_back(4'hA); exp_q.push_back(4'hB);
        d0 = done_cnt; b0 = beats;
        issue(14, 4, t0);
        wait_done("t2_done", d0 + 1, 40);
        #1;
        check("t2_ram_a_end", ram_a, 2);
        check("t2_beats", beats - b0, 4);
        check("t2_q_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);

        // 3: zero length
        d0 = done_cnt; b0 = beats;
        first_valid_cyc = -1;
        issue(7, 0, t0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("t3_busy", busy, 0);
        end
        check("t3_done_cnt", done_cnt, d0 + 1);
        check("t3_done_cyc", done_cyc, t0 + 1);
        check("t3_no_valid", first_valid_cyc, -1);
        check("t3_beats", beats - b0, 0);

        // 4: full-depth burst with toggling ready
        for (int i = 0; i < 16; i++) exp_q.push_back(DW'((5 + i) % 16) ^ 4'hA);
        d0 = done_cnt; b0 = beats;
        rdy_mode = 1'b1;
        issue(5, 16, t0);
        wait_done("t4_done", d0 + 1, 200);
        rdy_mode = 1'b0;
        check("t4_beats", beats - b0, 16);
        check("t4_q_empty", exp_q.size(), 0);
        repeat (3) @(posedge clk);

        // 5: start re-asserted mid-burst is ignored
        for (int i = 0; i < 6; i++) exp_q.push_back(DW'(8 + i) ^ 4'hA);
        d0 = done_cnt; b0 = beats;
        issue(8, 6, t0);
        @(posedge clk);
        #1;
        base_addr = '0;
        len       = (AW+1)'(3);
        start     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t5_done", d0 + 1, 40);
        repeat (5) @(posedge clk);
        #1;
        check("t5_single_done", done_cnt, d0 + 1);
        check("t5_beats", beats - b0, 6);
        check("t5_q_empty", exp_q.size(), 0);
        check("t5_idle", busy, 0);

        // 6: reset mid-burst with a full, stalled buffer
        rdy_const = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.push_back(4'h9);
        b0 = beats;
        issue(3, 5, t0);
        repeat (4) @(posedge clk);
        #1;
        check("t6_stalled_valid", m_valid, 1);
        check("t6_no_beats", beats - b0, 0);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", m_valid, 0);
        check("t6_rst_data", m_data, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ram_a", ram_a, 0);
        check("t6_rst_done", done, 0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_const = 1'b1;
        repeat (2) @(posedge clk);
        exp_q.push_back(4'h3); exp_q.push_back(4'h0); exp_q.push_back(4'h1);
        d0 = done_cnt; b0 = beats;
        issue(9, 3, t0);
        wait_done("t6_done", d0 + 1, 40);
        check("t6_beats", beats - b0, 3);
        check("t6_q_empty", exp_q.size(), 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
